// File: rtl/fetch_pkg.sv
// Shared types and constants for the RV32I fetch stage.
package fetch_pkg;

  typedef enum logic [2:0] {
    S_BOOT,
    S_REQ,
    S_HOLD,
    S_DISCARD,
    S_HALT
  } fetch_state_t;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

endpackage

// File: rtl/fetch_skid_buffer.sv
// One-entry holding register for an instruction word and its PC while decode is stalled.
module fetch_skid_buffer
  import fetch_pkg::*;
(
  input  logic        clk,
  input  logic        resetb,
  input  logic        i_load,
  input  logic        i_clear,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  output logic        o_valid,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc
);

  logic        r_valid;
  logic [31:0] r_inst;
  logic [31:0] r_pc;

  // Clear wins over load so a flush always empties the buffer.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_valid <= 1'b0;
      r_inst  <= NOP_INST;
      r_pc    <= 32'h0;
    end else if (i_clear) begin
      r_valid <= 1'b0;
    end else if (i_load) begin
      r_valid <= 1'b1;
      r_inst  <= i_inst;
      r_pc    <= i_pc;
    end
  end

  assign o_valid = r_valid;
  assign o_inst  = r_inst;
  assign o_pc    = r_pc;

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: owns the PC, runs a single-outstanding imem request and feeds decode over valid/ready.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = DEFAULT_RESET_PC
) (
  input  logic        clk,
  input  logic        resetb,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  output logic        inst_valid,
  input  logic        inst_ready,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
  input  logic        trap_valid,
  input  logic [31:0] trap_target,
  output logic        fetch_misaligned,
  output logic [31:0] misaligned_addr
);

  fetch_state_t r_state, w_state_next;

  logic [31:0] r_req_addr;
  logic [31:0] r_target;
  logic [31:0] r_inst;
  logic [31:0] r_inst_pc;
  logic        r_inst_valid;
  logic        r_misaligned;
  logic [31:0] r_mis_addr;
  logic        r_halt_pending;

  logic        w_in_flight;
  logic        w_flush;
  logic [31:0] w_flush_target;
  logic        w_flush_mis;
  logic        w_to_discard;
  logic        w_free;
  logic        w_skid_load;
  logic        w_skid_clear;
  logic        w_skid_valid;
  logic [31:0] w_skid_inst;
  logic [31:0] w_skid_pc;

  assign w_in_flight    = (r_state == S_REQ) || (r_state == S_DISCARD);
  // A halted fetch only responds to traps; redirects there are ignored.
  assign w_flush        = trap_valid | (redirect_valid & (r_state != S_HALT));
  assign w_flush_target = trap_valid ? trap_target : redirect_target;
  assign w_flush_mis    = !trap_valid && (redirect_target[1:0] != 2'b00);
  assign w_to_discard   = w_in_flight & !imem_ready;
  assign w_free         = !r_inst_valid | inst_ready;
  assign w_skid_load    = (r_state == S_REQ) & imem_ready & !w_free & !w_flush;
  assign w_skid_clear   = w_flush | ((r_state == S_HOLD) & inst_ready);

  fetch_skid_buffer u_skid (
    .clk     (clk),
    .resetb  (resetb),
    .i_load  (w_skid_load),
    .i_clear (w_skid_clear),
    .i_inst  (imem_rdata),
    .i_pc    (r_req_addr),
    .o_valid (w_skid_valid),
    .o_inst  (w_skid_inst),
    .o_pc    (w_skid_pc)
  );

  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) r_state <= S_BOOT;
    else         r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    if (w_flush) begin
      if (w_to_discard)     w_state_next = S_DISCARD;
      else if (w_flush_mis) w_state_next = S_HALT;
      else                  w_state_next = S_REQ;
    end else begin
      case (r_state)
        S_BOOT:    w_state_next = S_REQ;
        S_REQ:     if (imem_ready && !w_free) w_state_next = S_HOLD;
        S_HOLD:    if (inst_ready) w_state_next = S_REQ;
        S_DISCARD: if (imem_ready) w_state_next = r_halt_pending ? S_HALT : S_REQ;
        default:   w_state_next = r_state;
      endcase
    end
  end

  always_comb begin
    imem_req = (r_state == S_REQ) || (r_state == S_DISCARD);
  end

  // The outstanding address stays put during a discard; the new PC waits in r_target.
  always_ff @(posedge clk or negedge resetb) begin
    if (!resetb) begin
      r_req_addr     <= RESET_PC;
      r_target       <= RESET_PC;
      r_inst         <= NOP_INST;
      r_inst_pc      <= 32'h0;
      r_inst_valid   <= 1'b0;
      r_misaligned   <= 1'b0;
      r_mis_addr     <= 32'h0;
      r_halt_pending <= 1'b0;
    end else if (w_flush) begin
      r_inst_valid   <= 1'b0;
      r_misaligned   <= w_flush_mis;
      r_halt_pending <= w_flush_mis;
      if (w_flush_mis) r_mis_addr <= redirect_target;
      if (w_to_discard) r_target <= w_flush_target;
      else              r_req_addr <= w_flush_target;
    end else begin
      case (r_state)
        S_REQ: begin
          if (imem_ready) begin
            if (w_free) begin
              r_inst       <= imem_rdata;
              r_inst_pc    <= r_req_addr;
              r_inst_valid <= 1'b1;
            end
            r_req_addr <= r_req_addr + 32'd4;
          end else if (inst_ready) begin
            r_inst_valid <= 1'b0;
          end
        end
        S_HOLD: begin
          if (inst_ready && w_skid_valid) begin
            r_inst    <= w_skid_inst;
            r_inst_pc <= w_skid_pc;
          end
        end
        S_DISCARD: begin
          if (imem_ready) r_req_addr <= r_target;
        end
        default: ;
      endcase
    end
  end

  assign imem_addr        = r_req_addr;
  assign inst             = r_inst;
  assign inst_pc          = r_inst_pc;
  assign inst_valid       = r_inst_valid;
  assign fetch_misaligned = r_misaligned;
  assign misaligned_addr  = r_mis_addr;

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed bench for instruction_fetch: sequential fetch, stalls, redirects, traps, misalignment, wrap.
module tb_instruction_fetch;

  logic        clk;
  logic        resetb;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic [31:0] inst;
  logic [31:0] inst_pc;
  logic        inst_valid;
  logic        inst_ready;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        trap_valid;
  logic [31:0] trap_target;
  logic        fetch_misaligned;
  logic [31:0] misaligned_addr;

  int checks;
  int failures;

  instruction_fetch #(.RESET_PC(32'h0000_0100)) dut (
    .clk              (clk),
    .resetb           (resetb),
    .imem_req         (imem_req),
    .imem_addr        (imem_addr),
    .imem_ready       (imem_ready),
    .imem_rdata       (imem_rdata),
    .inst             (inst),
    .inst_pc          (inst_pc),
    .inst_valid       (inst_valid),
    .inst_ready       (inst_ready),
    .redirect_valid   (redirect_valid),
    .redirect_target  (redirect_target),
    .trap_valid       (trap_valid),
    .trap_target      (trap_target),
    .fetch_misaligned (fetch_misaligned),
    .misaligned_addr  (misaligned_addr)
  );

  // Memory model: every word is derived from its address so stale data is recognisable.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return a ^ 32'h5A5A_0000;
  endfunction

  assign imem_rdata = memWord(imem_addr);

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    resetb          = 1'b0;
    imem_ready      = 1'b1;
    inst_ready      = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    trap_valid      = 1'b0;
    trap_target     = 32'h0;
    #2;
    step();
    step();
    resetb = 1'b1;
    step();
  endtask

  task automatic test_reset();
    doReset();
    step();
    step();
    resetb = 1'b0;
    #2;
    checks++;
    if (inst_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_inst_valid actual=%b required=0", inst_valid);
    end
    checks++;
    if (inst !== 32'h0000_0013) begin
      failures++; $display("[TB] FAIL reset_inst_nop actual=%h required=00000013", inst);
    end
    checks++;
    if (inst_pc !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_inst_pc actual=%h required=00000000", inst_pc);
    end
    checks++;
    if (imem_req !== 1'b0) begin
      failures++; $display("[TB] FAIL reset_imem_req actual=%b required=0", imem_req);
    end
    checks++;
    if (imem_addr !== 32'h100) begin
      failures++; $display("[TB] FAIL reset_imem_addr actual=%h required=00000100", imem_addr);
    end
    checks++;
    if (fetch_misaligned !== 1'b0 || misaligned_addr !== 32'h0) begin
      failures++; $display("[TB] FAIL reset_misaligned actual=%b/%h required=0/00000000", fetch_misaligned, misaligned_addr);
    end
    step();
    resetb = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h100 || inst_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL boot_first_req actual=%b/%h/%b required=1/00000100/0", imem_req, imem_addr, inst_valid);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] expPc;
    doReset();
    for (int i = 0; i < 3; i++) begin
      step();
      expPc = 32'h100 + 32'(4 * i);
      checks++;
      if (inst_valid !== 1'b1 || inst_pc !== expPc || inst !== memWord(expPc)) begin
        failures++; $display("[TB] FAIL b2b_out[%0d] actual=%b/%h/%h required=1/%h/%h", i, inst_valid, inst_pc, inst, expPc, memWord(expPc));
      end
      checks++;
      if (imem_addr !== expPc + 32'd4) begin
        failures++; $display("[TB] FAIL b2b_addr[%0d] actual=%h required=%h", i, imem_addr, expPc + 32'd4);
      end
    end
  endtask

  task automatic test_stall();
    doReset();
    step();
    inst_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if (imem_req !== 1'b0 || inst_valid !== 1'b1 || inst_pc !== 32'h100) begin
        failures++; $display("[TB] FAIL stall_hold[%0d] actual=%b/%b/%h required=0/1/00000100", i, imem_req, inst_valid, inst_pc);
      end
    end
    inst_ready = 1'b1;
    step();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h104 || inst !== memWord(32'h104)) begin
      failures++; $display("[TB] FAIL stall_skid_out actual=%b/%h/%h required=1/00000104/%h", inst_valid, inst_pc, inst, memWord(32'h104));
    end
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h108) begin
      failures++; $display("[TB] FAIL stall_resume_addr actual=%b/%h required=1/00000108", imem_req, imem_addr);
    end
    step();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h108) begin
      failures++; $display("[TB] FAIL stall_next_pc actual=%b/%h required=1/00000108", inst_valid, inst_pc);
    end
  endtask

  task automatic test_redirect();
    doReset();
    step();
    step();
    step();
    imem_ready = 1'b0;
    step();
    checks++;
    if (imem_addr !== 32'h10C || inst_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL redir_wait_pre actual=%h/%b required=0000010c/0", imem_addr, inst_valid);
    end
    redirect_valid  = 1'b1;
    redirect_target = 32'h200;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      checks++;
      if (imem_req !== 1'b1 || imem_addr !== 32'h10C || inst_valid !== 1'b0) begin
        failures++; $display("[TB] FAIL redir_drain[%0d] actual=%b/%h/%b required=1/0000010c/0", i, imem_req, imem_addr, inst_valid);
      end
      if (i == 0) step();
    end
    imem_ready = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b1 || imem_addr !== 32'h200 || inst_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL redir_new_addr actual=%b/%h/%b required=1/00000200/0", imem_req, imem_addr, inst_valid);
    end
    step();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h200 || inst !== memWord(32'h200)) begin
      failures++; $display("[TB] FAIL redir_first_inst actual=%b/%h/%h required=1/00000200/%h", inst_valid, inst_pc, inst, memWord(32'h200));
    end
  endtask

  task automatic test_trap_priority();
    doReset();
    step();
    redirect_valid  = 1'b1;
    redirect_target = 32'h300;
    trap_valid      = 1'b1;
    trap_target     = 32'h80;
    step();
    redirect_valid = 1'b0;
    trap_valid     = 1'b0;
    checks++;
    if (imem_addr !== 32'h80 || inst_valid !== 1'b0) begin
      failures++; $display("[TB] FAIL trap_prio_addr actual=%h/%b required=00000080/0", imem_addr, inst_valid);
    end
    step();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h80 || inst !== memWord(32'h80)) begin
      failures++; $display("[TB] FAIL trap_prio_inst actual=%b/%h/%h required=1/00000080/%h", inst_valid, inst_pc, inst, memWord(32'h80));
    end
  endtask

  task automatic test_misaligned();
    doReset();
    step();
    redirect_valid  = 1'b1;
    redirect_target = 32'h202;
    step();
    redirect_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (fetch_misaligned !== 1'b1 || misaligned_addr !== 32'h202 || imem_req !== 1'b0 || inst_valid !== 1'b0) begin
        failures++; $display("[TB] FAIL mis_halt[%0d] actual=%b/%h/%b/%b required=1/00000202/0/0", i, fetch_misaligned, misaligned_addr, imem_req, inst_valid);
      end
      step();
    end
    trap_valid  = 1'b1;
    trap_target = 32'h80;
    step();
    trap_valid = 1'b0;
    checks++;
    if (fetch_misaligned !== 1'b0 || imem_req !== 1'b1 || imem_addr !== 32'h80) begin
      failures++; $display("[TB] FAIL mis_trap_exit actual=%b/%b/%h required=0/1/00000080", fetch_misaligned, imem_req, imem_addr);
    end
    step();
    checks++;
    if (inst_valid !== 1'b1 || inst_pc !== 32'h80) begin
      failures++; $display("[TB] FAIL mis_trap_inst actual=%b/%h required=1/00000080", inst_valid, inst_pc);
    end
    doReset();
    imem_ready      = 1'b0;
    redirect_valid  = 1'b1;
    redirect_target = 32'h206;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (fetch_misaligned !== 1'b1 || imem_req !== 1'b1 || imem_addr !== 32'h100) begin
      failures++; $display("[TB] FAIL mis_drain actual=%b/%b/%h required=1/1/00000100", fetch_misaligned, imem_req, imem_addr);
    end
    imem_ready = 1'b1;
    step();
    checks++;
    if (imem_req !== 1'b0 || inst_valid !== 1'b0 || misaligned_addr !== 32'h206) begin
      failures++; $display("[TB] FAIL mis_drain_halt actual=%b/%b/%h required=0/0/00000206", imem_req, inst_valid, misaligned_addr);
    end
  endtask

  task automatic test_wrap();
    doReset();
    redirect_valid  = 1'b1;
    redirect_target = 32'hFFFF_FFFC;
    step();
    redirect_valid = 1'b0;
    checks++;
    if (imem_addr !== 32'hFFFF_FFFC) begin
      failures++; $display("[TB] FAIL wrap_top_addr actual=%h required=fffffffc", imem_addr);
    end
    step();
    checks++;
    if (imem_addr !== 32'h0 || inst_pc !== 32'hFFFF_FFFC || inst_valid !== 1'b1) begin
      failures++; $display("[TB] FAIL wrap_zero actual=%h/%h/%b required=00000000/fffffffc/1", imem_addr, inst_pc, inst_valid);
    end
  endtask

  initial begin
    checks          = 0;
    failures        = 0;
    resetb          = 1'b0;
    imem_ready      = 1'b1;
    inst_ready      = 1'b1;
    redirect_valid  = 1'b0;
    redirect_target = 32'h0;
    trap_valid      = 1'b0;
    trap_target     = 32'h0;
    test_reset();
    test_back_to_back();
    test_stall();
    test_redirect();
    test_trap_priority();
    test_misaligned();
    test_wrap();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage of the RV32I embedded softcore; sits directly upstream of instruction_decoder and drives its inst input.
- Owns the PC and runs a single-outstanding-request handshake to instruction memory.
- Presents one instruction plus its PC to decode over a valid/ready pair.
- Accepts redirects (jump/branch/MRET) and trap vectors from execute/CSR, flushes wrong-path fetches, and flags misaligned targets.

Parameters:
- RESET_PC, 32'h0000_0000, PC fetched first after reset.

Ports:
- clk  in  1  clock; all state updates on rising edge
- resetb  in  1  asynchronous active-low reset
- imem_req  out  1  fetch request
- imem_addr  out  32  fetch address, word aligned
- imem_ready  in  1  response valid this cycle; ignored when imem_req=0
- imem_rdata  in  32  instruction word, valid when imem_req&imem_ready
- inst  out  32  instruction to decoder
- inst_pc  out  32  PC of inst
- inst_valid  out  1  inst/inst_pc valid
- inst_ready  in  1  decoder consumes this cycle
- redirect_valid  in  1  control-flow change (jump/jr/br taken/MRET)
- redirect_target  in  32  new PC
- trap_valid  in  1  trap entry
- trap_target  in  32  trap vector (mtvec), assumed aligned
- fetch_misaligned  out  1  level: redirect target not word aligned, fetch halted
- misaligned_addr  out  32  offending target

Behaviour:
- Reset (async, resetb=0):
  - pc=RESET_PC, req_addr=RESET_PC, state=S_BOOT.
  - imem_req=0, inst_valid=0, inst=32'h0000_0013 (NOP), inst_pc=0.
  - Skid buffer empty, fetch_misaligned=0, misaligned_addr=0.
  - Reset asserted mid-request abandons the request; the memory side must tolerate this.
- States: S_BOOT, S_REQ, S_HOLD, S_DISCARD, S_HALT.
- S_BOOT: one cycle, then S_REQ.
- Request signals: imem_req=1 in S_REQ and S_DISCARD only. imem_addr=req_addr register, held stable until imem_ready.
- S_REQ, response (imem_ready=1):
  - If output slot free or consumed this cycle (!inst_valid | inst_ready): inst<=imem_rdata, inst_pc<=req_addr, inst_valid<=1, req_addr<=req_addr+4, stay S_REQ.
  - Zero-wait memory therefore sustains 1 instruction/cycle.
  - Otherwise: capture word and PC into the skid buffer, req_addr<=req_addr+4, go S_HOLD.
- S_REQ, no response: on inst_ready, inst_valid<=0.
- S_HOLD: imem_req=0. On inst_ready, move skid to output (inst_valid stays 1) and go S_REQ.
- Event priority: trap_valid > redirect_valid > normal fetch. Both are evaluated in any state.
- Flush (trap or redirect, aligned target):
  - inst_valid<=0, skid cleared, req_addr<=target, fetch_misaligned<=0.
  - If in S_REQ/S_DISCARD with imem_ready=0, go S_DISCARD.
  - Otherwise go S_REQ; a same-cycle response is dropped.
- S_DISCARD:
  - imem_req=1 at the old address. req_addr is not changed until the response arrives, so a separate target register holds the new PC.
  - Drop the response, load req_addr from the target register, go S_REQ.
  - Further redirects in S_DISCARD overwrite the target register.
- Misaligned redirect (redirect_target[1:0]!=0, no trap):
  - Flush as above; fetch_misaligned<=1, misaligned_addr<=redirect_target.
  - Outstanding request is drained as in S_DISCARD, then go S_HALT.
  - S_HALT: imem_req=0, inst_valid=0. Only trap_valid leaves it.
- PC arithmetic: req_addr+4 is modulo 2^32, so 32'hFFFF_FFFC wraps to 0.
- Decoder-visible outputs change only on clk edges; no combinational path from imem_rdata to inst.

Decomposition:
- Package fetch_pkg:
  - state enumeration localparams
  - NOP constant 32'h0000_0013
  - default RESET_PC
- One natural sub-module: fetch_skid_buffer, a 1-entry inst/pc holding register with valid, load and clear.

Test Plan:
- Reset with RESET_PC=0x100, imem_ready tied 1, inst_ready=1 → imem_addr 0x100,0x104,0x108 on consecutive cycles; inst_pc matches one cycle later; inst=NOP during reset.
- Decoder stall: inst_ready=0 for 3 cycles after the first instruction → the second word lands in skid, imem_req drops; on release inst_pc sequence is 0x100,0x104,0x108 with no loss or duplication.
- Redirect to 0x200 while request to 0x10C waits 2 cycles → imem_addr stays 0x10C until ready, its data is never presented; next imem_addr=0x200; inst_valid low meanwhile.
- Same cycle: redirect_valid to 0x300 and trap_valid to 0x80 → fetch resumes at 0x80.
- Redirect to 0x202 → fetch_misaligned=1, misaligned_addr=0x202, imem_req=0 until trap_valid to 0x80; then fetch_misaligned=0 and fetch at 0x80.
- Sequential fetch from 0xFFFF_FFFC → next imem_addr=0x0000_0000.
